// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the scrolling pipe field.
package pipe_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_GROUND_Y = 428;
  localparam int BORDER       = 3;
  localparam int BODY_OFF     = 9;

  function automatic logic [15:0] clamp16(input logic [15:0] v,
                                          input logic [15:0] lo,
                                          input logic [15:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pipe_lane.sv
// One pipe pair: scrolling X / top-length registers plus its pixel classifier.
module pipe_lane
  import pipe_pkg::*;
#(
  parameter int INIT_X      = 640,
  parameter int SPAN        = 720,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int PIPE_W      = 90,
  parameter int CAP_H       = 33,
  parameter int GAP_H       = 117,
  parameter int GROUND_Y    = DEF_GROUND_Y,
  parameter int MIN_TOP     = 20,
  parameter int DEFAULT_TOP = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic [15:0] pipes_long,
  input  logic [15:0] counter_x,
  input  logic [15:0] counter_y,
  output logic [15:0] x,
  output logic [15:0] top,
  output logic        green,
  output logic        black
);

  localparam logic [15:0] TOP_MAX = 16'(GROUND_Y - GAP_H - 2*CAP_H - MIN_TOP);
  localparam logic [15:0] W    = 16'(PIPE_W);
  localparam logic [15:0] CH   = 16'(CAP_H);
  localparam logic [15:0] GH   = 16'(GAP_H);
  localparam logic [15:0] GY   = 16'(GROUND_Y);
  localparam logic [15:0] BRD  = 16'(BORDER);
  localparam logic [15:0] BOFF = 16'(BODY_OFF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      x   <= 16'(INIT_X);
      top <= 16'(DEFAULT_TOP);
    end else if (advance) begin
      if (x == '0) begin
        x   <= 16'(SPAN - 1);
        top <= clamp16(pipes_long, 16'(MIN_TOP), TOP_MAX);
      end else begin
        x <= x - 16'd1;
      end
    end
  end

  logic [15:0] bot_y, body_l, body_r;
  logic visible, cap_cols, cap_side, body_cols, body_side;
  logic top_body, top_cap, top_cap_edge, bot_cap, bot_cap_edge, bot_body;
  logic paint;

  assign bot_y  = top + CH + GH;
  assign body_l = x + BOFF;
  assign body_r = x + W - BOFF;

  // Pipes parked past the right edge (respawned or not yet scrolled in) stay dark.
  assign visible   = x <= 16'(SCREEN_W);
  assign cap_cols  = counter_x >= x && counter_x <= x + W;
  assign cap_side  = counter_x < x + BRD || counter_x > x + W - BRD;
  assign body_cols = counter_x >= body_l && counter_x <= body_r;
  assign body_side = counter_x < body_l + BRD || counter_x > body_r - BRD;

  assign top_body     = counter_y < top;
  assign top_cap      = counter_y >= top && counter_y <= top + CH;
  assign top_cap_edge = counter_y < top + BRD || counter_y > top + CH - BRD;
  assign bot_cap      = counter_y >= bot_y && counter_y <= bot_y + CH;
  assign bot_cap_edge = counter_y < bot_y + BRD || counter_y > bot_y + CH - BRD;
  assign bot_body     = counter_y >= bot_y + CH && counter_y <= GY;

  assign black = visible &&
                 ((cap_cols && ((top_cap && (cap_side || top_cap_edge)) ||
                                (bot_cap && (cap_side || bot_cap_edge)))) ||
                  (body_cols && body_side && (top_body || bot_body)));
  assign paint = visible && ((cap_cols && (top_cap || bot_cap)) ||
                             (body_cols && (top_body || bot_body)));
  assign green = paint && !black;

endmodule

// File: rtl/pipe_field.sv
// Scrolling pipe field: start/run/halt sequencing, per-lane pipes, pixel and score outputs.
// state   | meaning
// ST_IDLE | waiting for button, pipes parked at reset positions
// ST_RUN  | pipes scroll one pixel per step tick
// ST_HALT | collision seen, everything frozen until reset
module pipe_field
  import pipe_pkg::*;
#(
  parameter int N_PIPES     = 3,
  parameter int SPACING     = 240,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int PIPE_W      = 90,
  parameter int CAP_H       = 33,
  parameter int GAP_H       = 117,
  parameter int GROUND_Y    = DEF_GROUND_Y,
  parameter int MIN_TOP     = 20,
  parameter int DEFAULT_TOP = 100,
  parameter int BIRD_X      = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_tick,
  input  logic        button,
  input  logic        status,
  input  logic [15:0] pipes_long,
  input  logic [15:0] counter_x,
  input  logic [15:0] counter_y,
  output logic        pipe_green,
  output logic        pipe_black,
  output logic        score_pulse,
  output logic [15:0] near_pipe_x,
  output logic [15:0] near_pipe_top,
  output logic        running
);

  localparam int SPAN = N_PIPES * SPACING;

  if (N_PIPES < 1 || N_PIPES > 8) begin : g_bad_count
    $error("pipe_field: N_PIPES must be 1..8");
  end
  if (SPAN - 1 < SCREEN_W) begin : g_bad_span
    $error("pipe_field: N_PIPES*SPACING-1 must reach SCREEN_W");
  end

  logic [1:0] state;
  logic       move;

  // A collision on the same cycle as a tick wins: no movement.
  assign move    = (state == ST_RUN) && step_tick && status;
  assign running = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (!button) state <= ST_RUN;
        ST_RUN:  if (!status) state <= ST_HALT;
        ST_HALT: ;
        default: state <= ST_HALT;
      endcase
    end
  end

  logic [15:0]        lane_x   [N_PIPES];
  logic [15:0]        lane_top [N_PIPES];
  logic [N_PIPES-1:0] lane_green, lane_black, lane_at_bird;

  for (genvar i = 0; i < N_PIPES; i++) begin : g_lane
    pipe_lane #(
      .INIT_X     (SCREEN_W + i * SPACING),
      .SPAN       (SPAN),
      .SCREEN_W   (SCREEN_W),
      .PIPE_W     (PIPE_W),
      .CAP_H      (CAP_H),
      .GAP_H      (GAP_H),
      .GROUND_Y   (GROUND_Y),
      .MIN_TOP    (MIN_TOP),
      .DEFAULT_TOP(DEFAULT_TOP)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .advance   (move),
      .pipes_long(pipes_long),
      .counter_x (counter_x),
      .counter_y (counter_y),
      .x         (lane_x[i]),
      .top       (lane_top[i]),
      .green     (lane_green[i]),
      .black     (lane_black[i])
    );
    assign lane_at_bird[i] = (lane_x[i] == 16'(BIRD_X));
  end

  logic [15:0] near_x_c, near_top_c;
  logic        near_found;

  // Strict less-than keeps the lowest index on equal X.
  always_comb begin
    near_x_c   = '0;
    near_top_c = '0;
    near_found = 1'b0;
    for (int i = 0; i < N_PIPES; i++) begin
      if (lane_x[i] + 16'(PIPE_W) >= 16'(BIRD_X) &&
          (!near_found || lane_x[i] < near_x_c)) begin
        near_found = 1'b1;
        near_x_c   = lane_x[i];
        near_top_c = lane_top[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_green    <= 1'b0;
      pipe_black    <= 1'b0;
      score_pulse   <= 1'b0;
      near_pipe_x   <= '0;
      near_pipe_top <= '0;
    end else begin
      pipe_black    <= |lane_black;
      pipe_green    <= (|lane_green) && !(|lane_black);
      score_pulse   <= move && (|lane_at_bird);
      near_pipe_x   <= near_x_c;
      near_pipe_top <= near_top_c;
    end
  end

endmodule

// File: tb/tb_pipe_field.sv
// Self-checking bench for pipe_field: rectangle-level reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_pipe_field;

  localparam int NP = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic reset, step_tick, button, status;
  logic [15:0] pipes_long, counter_x, counter_y;
  logic pipe_green, pipe_black, score_pulse, running;
  logic [15:0] near_pipe_x, near_pipe_top;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_field dut (
    .clk(clk), .reset(reset), .step_tick(step_tick), .button(button),
    .status(status), .pipes_long(pipes_long), .counter_x(counter_x),
    .counter_y(counter_y), .pipe_green(pipe_green), .pipe_black(pipe_black),
    .score_pulse(score_pulse), .near_pipe_x(near_pipe_x),
    .near_pipe_top(near_pipe_top), .running(running)
  );

  // Reference model: pipe positions as plain integers, drawing as rectangles.
  int   m_state;
  int   m_x   [NP];
  int   m_top [NP];
  logic e_green, e_black, e_score;
  int   e_near_x, e_near_top;

  function automatic bit in_box(input int px, input int py, input int l,
                                input int r, input int t, input int b);
    return px >= l && px <= r && py >= t && py <= b;
  endfunction

  // Returns {black, green}; a border is the outer rectangle minus its interior.
  function automatic bit [1:0] model_pixel(input int cx, input int cy);
    bit blk, pnt;
    blk = 1'b0;
    pnt = 1'b0;
    for (int i = 0; i < NP; i++) begin
      int X, T, B;
      X = m_x[i];
      T = m_top[i];
      B = T + 150;
      if (X <= 640) begin
        if (in_box(cx, cy, X, X+90, T, T+33) && !in_box(cx, cy, X+3, X+87, T+3, T+30)) blk = 1'b1;
        if (in_box(cx, cy, X, X+90, B, B+33) && !in_box(cx, cy, X+3, X+87, B+3, B+30)) blk = 1'b1;
        if (in_box(cx, cy, X+9, X+81, 0, T-1) && !in_box(cx, cy, X+12, X+78, 0, T-1)) blk = 1'b1;
        if (in_box(cx, cy, X+9, X+81, B+33, 428) && !in_box(cx, cy, X+12, X+78, B+33, 428)) blk = 1'b1;
        if (in_box(cx, cy, X, X+90, T, T+33) || in_box(cx, cy, X, X+90, B, B+33) ||
            in_box(cx, cy, X+9, X+81, 0, T-1) || in_box(cx, cy, X+9, X+81, B+33, 428)) pnt = 1'b1;
      end
    end
    return {blk, pnt && !blk};
  endfunction

  function automatic int model_near();
    int best;
    best = -1;
    for (int i = 0; i < NP; i++)
      if (m_x[i] + 90 >= 100 && (best < 0 || m_x[i] < m_x[best])) best = i;
    return best;
  endfunction

  function automatic bit model_at_bird();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < NP; i++) if (m_x[i] == 100) hit = 1'b1;
    return hit;
  endfunction

  function automatic int clamp_top(input int v);
    return (v < 20) ? 20 : ((v > 225) ? 225 : v);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_state <= M_IDLE;
      for (int i = 0; i < NP; i++) begin
        m_x[i]   <= 640 + i * 240;
        m_top[i] <= 100;
      end
      e_green <= 1'b0; e_black <= 1'b0; e_score <= 1'b0;
      e_near_x <= 0; e_near_top <= 0;
    end else begin
      {e_black, e_green} <= model_pixel(int'(counter_x), int'(counter_y));
      e_score <= (m_state == M_RUN) && step_tick && status && model_at_bird();
      if (model_near() >= 0) begin
        e_near_x   <= m_x[model_near()];
        e_near_top <= m_top[model_near()];
      end else begin
        e_near_x   <= 0;
        e_near_top <= 0;
      end
      if (m_state == M_IDLE && !button) m_state <= M_RUN;
      else if (m_state == M_RUN && !status) m_state <= M_HALT;
      else if (m_state == M_RUN && step_tick) begin
        for (int i = 0; i < NP; i++) begin
          if (m_x[i] == 0) begin
            m_x[i]   <= 719;
            m_top[i] <= clamp_top(int'(pipes_long));
          end else begin
            m_x[i] <= m_x[i] - 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("green",    int'(pipe_green),    int'(e_green));
      check("black",    int'(pipe_black),    int'(e_black));
      check("score",    int'(score_pulse),   int'(e_score));
      check("near_x",   int'(near_pipe_x),   e_near_x);
      check("near_top", int'(near_pipe_top), e_near_top);
      check("running",  int'(running),       int'(m_state == M_RUN));
    end
  end

  task automatic step(input logic t);
    step_tick = t;
    @(posedge clk);
    #1;
    step_tick = 1'b0;
  endtask

  task automatic rand_pixel();
    counter_x = 16'($urandom_range(0, 760));
    counter_y = 16'($urandom_range(0, 470));
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      rand_pixel();
      step(1'b1);
      rand_pixel();
      step(1'b0);
    end
  endtask

  task automatic pix(input int cx, input int cy, input int eg, input int eb, input string tag);
    counter_x = 16'(cx);
    counter_y = 16'(cy);
    step(1'b0);
    @(negedge clk);
    check({tag, "_green"}, int'(pipe_green), eg);
    check({tag, "_black"}, int'(pipe_black), eb);
  endtask

  initial begin
    reset = 1'b0; step_tick = 1'b0; button = 1'b1; status = 1'b1;
    pipes_long = 16'd50; counter_x = 16'd210; counter_y = 16'd110;
    @(posedge clk); #1;
    chk_en = 1'b1;
    step(1'b0);
    @(negedge clk);
    check("rst_near_x", int'(near_pipe_x), 0);
    check("rst_running", int'(running), 0);

    reset = 1'b1;
    step(1'b0);
    @(negedge clk);
    check("idle_near_x", int'(near_pipe_x), 640);
    check("idle_near_top", int'(near_pipe_top), 100);

    // start and tick together: only the transition happens
    button = 1'b0;
    step(1'b1);
    button = 1'b1;
    @(negedge clk);
    check("start_running", int'(running), 1);
    step(1'b0);
    @(negedge clk);
    check("start_no_move", int'(near_pipe_x), 640);

    do_ticks(440);
    pix(200, 100, 0, 1, "cap_corner");
    pix(210, 110, 1, 0, "cap_inner");
    pix(205, 50, 0, 0, "outside_body");
    pix(245, 300, 1, 0, "bottom_body");

    do_ticks(100);
    check("pre_score", int'(score_pulse), 0);
    step(1'b1);
    @(negedge clk);
    check("score_hi", int'(score_pulse), 1);
    step(1'b0);
    @(negedge clk);
    check("score_lo", int'(score_pulse), 0);

    do_ticks(99);
    check("t640_near_x", int'(near_pipe_x), 240);
    pipes_long = 16'd5;
    do_ticks(1);
    check("t641_near_x", int'(near_pipe_x), 239);
    check("t641_near_top", int'(near_pipe_top), 100);
    check("model_x0", m_x[0], 719);
    check("model_top0", m_top[0], 20);

    do_ticks(79);
    pix(640, 20, 0, 1, "clamp_lo_edge");
    pix(650, 30, 1, 0, "clamp_lo_cap");

    pipes_long = 16'hFFFF;
    do_ticks(161);
    check("model_top1", m_top[1], 225);
    do_ticks(79);
    pix(640, 225, 0, 1, "clamp_hi_edge");

    // collision and tick on the same cycle, then a frozen field
    status = 1'b0;
    step(1'b1);
    status = 1'b1;
    @(negedge clk);
    check("halt_running", int'(running), 0);
    button = 1'b0;
    repeat (100) begin
      rand_pixel();
      step(1'b1);
    end
    button = 1'b1;
    @(negedge clk);
    check("halt_near_x", int'(near_pipe_x), 160);
    check("halt_near_top", int'(near_pipe_top), 100);
    check("halt_stays", int'(running), 0);

    reset = 1'b0;
    step(1'b0);
    @(negedge clk);
    check("rst2_near_x", int'(near_pipe_x), 0);
    check("rst2_score", int'(score_pulse), 0);
    reset = 1'b1;
    step(1'b0);
    @(negedge clk);
    check("rst2_idle_x", int'(near_pipe_x), 640);
    check("rst2_idle_run", int'(running), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_field.md
PIPE_FIELD -- requirements
Module: pipe_field

Interface
REQ-001 Parameter N_PIPES, 3, number of concurrently scrolling pipe pairs (1..8).
REQ-002 Parameter SPACING, 240, horizontal pitch between consecutive pipes in pixels.
REQ-003 Parameter SCREEN_W, 640, visible width; initial X of pipe 0.
REQ-004 Parameter PIPE_W, 90, cap width; body spans X+9..X+81, side borders 3 px.
REQ-005 Parameter CAP_H, 33, cap height; cap border 3 px.
REQ-006 Parameter GAP_H, 117, clear vertical gap between top-cap bottom and bottom-cap top.
REQ-007 Parameter GROUND_Y, 428, last row of bottom body.
REQ-008 Parameters MIN_TOP 20 and DEFAULT_TOP 100, top-length clamp floor and reset value.
REQ-009 Parameter BIRD_X, 100, scoring column.
REQ-010 Clk  in  1  system clock; all state on rising edge.
REQ-011 Reset  in  1  synchronous, active-low reset.
REQ-012 StepTick  in  1  one-cycle move strobe (one pixel per strobe).
REQ-013 Button  in  1  active-low start request.
REQ-014 Status  in  1  1 = bird alive, 0 = collision/game over.
REQ-015 PipesLong  in  16  random top-pipe length, sampled on respawn.
REQ-016 CounterX, CounterY  in  16 each  current scan pixel.
REQ-017 PipeGreen, PipeBlack  out  1 each  registered pixel class, mutually exclusive.
REQ-018 ScorePulse  out  1  one-cycle pulse per pipe passing BIRD_X.
REQ-019 NearPipeX, NearPipeTop  out  16 each  X and top length of nearest pipe not yet fully passed.
REQ-020 Running  out  1  high in RUN state.

Function
REQ-021 States IDLE, RUN, HALT; IDLE->RUN when Button==0; RUN->HALT when Status==0; HALT exits only via Reset.
REQ-022 Pipe i X moves only in RUN on StepTick; X_i==0 -> X_i <= N_PIPES*SPACING-1 (respawn), else X_i-1.
REQ-023 On respawn Top_i <= clamp(PipesLong, MIN_TOP, GROUND_Y-GAP_H-2*CAP_H-MIN_TOP).
REQ-024 Design-time check: N_PIPES*SPACING-1 >= SCREEN_W; elaboration error otherwise.
REQ-025 Top body: X+9..X+81, rows 0..Top-1; cap: X..X+PIPE_W, rows Top..Top+CAP_H.
REQ-026 Bottom cap top B = Top+CAP_H+GAP_H; cap rows B..B+CAP_H; body rows B+CAP_H..GROUND_Y.
REQ-027 Border pixels black, interiors green; black wins over green across all pipes; outputs OR of all lanes.
REQ-028 Pixel outputs registered: 1-cycle latency from CounterX/CounterY.
REQ-029 ScorePulse asserted the cycle after a RUN StepTick where some X_i==BIRD_X; at most one pulse per tick.
REQ-030 NearPipe = smallest X_i with X_i+PIPE_W >= BIRD_X; ties -> lowest index; registered, 1-cycle latency.
REQ-031 Button and StepTick in same IDLE cycle: transition only, no movement that cycle.
REQ-032 Status==0 and StepTick same RUN cycle: no movement, enter HALT; positions frozen in HALT.
REQ-033 Arithmetic 16-bit unsigned; X values > SCREEN_W are off-screen and draw nothing.

Reset
REQ-034 Reset==0 at any state: state IDLE, X_i = SCREEN_W + i*SPACING, Top_i = DEFAULT_TOP, all outputs 0 next edge.

Structure
REQ-035 Shared package pipe_pkg: state encoding, SCREEN_W, GROUND_Y, border constants, clamp function.
REQ-036 Sub-module pipe_lane (one X/Top register pair plus pixel classifier) instantiated N_PIPES times by generate.

Verification
REQ-037 Reset, Button=0, 640 ticks -> X0=0, X1=240; tick 641 -> X0=719, X1=239, Top0 = clamped PipesLong.
REQ-038 From reset run 540 ticks (X0=100); tick 541 -> ScorePulse high exactly one cycle.
REQ-039 Force X=200, Top=100: pixel (200,100) black, (210,110) green, (205,50) none, (245,300) green.
REQ-040 PipesLong=5 and 0xFFFF at respawn -> Top=20 and Top=225 respectively.
REQ-041 Status=0 mid-run with StepTick same cycle -> HALT, X frozen over 100 ticks, Button ignored; Reset -> IDLE values.
